// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//
// Serial configuration-chain controller for routing tiles. Configuration words arrive on a
// valid/ready stream and are shifted LSB-first onto the tile's ccff_head input while
// config_enable_o is high, one chain bit per enabled prog_clk edge. The load ends after
// exactly CHAIN_LEN shifts. Upper bits of the final word are discarded when CHAIN_LEN is
// not a multiple of WORD_W.
//
// Optional feature (macro CCFF_LOADER_READBACK_EN): rb_ones_o counts the ones displaced
// out of ccff_tail during the load, i.e. the popcount of the chain's previous contents.
// Without the macro, rb_ones_o is tied to 0 and ccff_tail_i is unused.
//
// Ports:
//   prog_clk_i       configuration clock, all state changes on the rising edge
//   p_reset_i        asynchronous active-high reset
//   start_i          begin a load (sampled only in idle)
//   abort_i          cancel a load in progress
//   cfg_data_i       configuration word, LSB shifted first
//   cfg_valid_i      cfg_data_i is valid
//   cfg_ready_o      a word is accepted this cycle when cfg_valid_i is high
//   config_enable_o  chain shift enable
//   ccff_head_o      serial bit into the chain
//   ccff_tail_i      serial bit out of the chain
//   busy_o           load in progress
//   done_o           one-cycle pulse when the load completes
//   bit_cnt_o        bits shifted in the current load
//   rb_ones_o        readback popcount

module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 52,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              prog_clk_i,
  input  logic              p_reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic              config_enable_o,
  output logic              ccff_head_o,
  input  logic              ccff_tail_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  bit_cnt_o,
  output logic [CNT_W-1:0]  rb_ones_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WordLen  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo   = CNT_W'(2);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  // Bits of the current word still to be shifted, including the one on ccff_head.
  logic [CNT_W-1:0]    left_q, left_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic                head_q, head_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                capture;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    cap_cnt;
  logic [CNT_W-1:0]    cap_room;
  logic [CNT_W-1:0]    cap_bits;

  assign cnt_inc  = bit_cnt_q + CntOne;
  // Chain position at which a word captured this cycle starts shifting.
  assign cap_cnt  = (state_q == StShift) ? cnt_inc : bit_cnt_q;
  assign cap_room = ChainLen - cap_cnt;
  assign cap_bits = (cap_room < WordLen) ? cap_room : WordLen;

`ifdef CCFF_LOADER_READBACK_EN
  logic [CNT_W-1:0] rb_q, rb_d;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail_i;
`endif

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    left_d    = left_q;
    bit_cnt_d = bit_cnt_q;
    ready_d   = ready_q;
    en_d      = en_q;
    head_d    = head_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    capture   = 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
    rb_d      = rb_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoad;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          ready_d   = 1'b1;
          en_d      = 1'b0;
          head_d    = 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
          rb_d      = '0;
`endif
        end
      end

      StLoad: begin
        if (abort_i) begin
          state_d = StIdle;
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end else if (cfg_valid_i) begin
          capture = 1'b1;
        end
      end

      StShift: begin
        if (abort_i) begin
          // The aborted cycle is not counted as a shift.
          state_d = StIdle;
          en_d    = 1'b0;
          head_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          bit_cnt_d = cnt_inc;
`ifdef CCFF_LOADER_READBACK_EN
          if (ccff_tail_i) rb_d = rb_q + CntOne;
`endif
          if (cnt_inc == ChainLen) begin
            state_d = StDone;
            en_d    = 1'b0;
            head_d  = 1'b0;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (left_q == CntOne) begin
            // ready_q is high here, so valid alone completes the handshake.
            if (cfg_valid_i) begin
              capture = 1'b1;
            end else begin
              state_d = StLoad;
              en_d    = 1'b0;
              head_d  = 1'b0;
              ready_d = 1'b1;
            end
          end else begin
            head_d  = buf_q[0];
            buf_d   = buf_q >> 1;
            left_d  = left_q - CntOne;
            ready_d = (left_q == CntTwo) && ((bit_cnt_q + CntTwo) < ChainLen);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (capture) begin
      state_d = StShift;
      head_d  = cfg_data_i[0];
      buf_d   = cfg_data_i >> 1;
      left_d  = cap_bits;
      en_d    = 1'b1;
      busy_d  = 1'b1;
      // A one-bit word is its own last cycle; ready then unless it is the final chain bit.
      ready_d = (cap_bits == CntOne) && ((cap_cnt + CntOne) < ChainLen);
    end
  end

  always_ff @(posedge prog_clk_i or posedge p_reset_i) begin
    if (p_reset_i) begin
      state_q   <= StIdle;
      buf_q     <= '0;
      left_q    <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b0;
      en_q      <= 1'b0;
      head_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
      rb_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      left_q    <= left_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      en_q      <= en_d;
      head_q    <= head_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CCFF_LOADER_READBACK_EN
      rb_q      <= rb_d;
`endif
    end
  end

  assign cfg_ready_o     = ready_q;
  assign config_enable_o = en_q;
  assign ccff_head_o     = head_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign bit_cnt_o       = bit_cnt_q;
`ifdef CCFF_LOADER_READBACK_EN
  assign rb_ones_o       = rb_q;
`else
  assign rb_ones_o       = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader. The reference is a flat bit stream built from
// the word table (word k bit j lands at stream position k*W+j, truncated to L bits) plus a
// behavioural model of the attached ccff chain that supplies ccff_tail.

module tb_ccff_chain_loader;

  localparam int unsigned L  = 52;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned NW = (L + W - 1) / W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic          en;
  logic          head;
  logic          tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] rb;

  always #5 clk = ~clk;

  ccff_chain_loader #(
    .CHAIN_LEN (L),
    .WORD_W    (W),
    .CNT_W     (CW)
  ) dut (
    .prog_clk_i      (clk),
    .p_reset_i       (rst),
    .start_i         (start),
    .abort_i         (abort),
    .cfg_data_i      (data),
    .cfg_valid_i     (valid),
    .cfg_ready_o     (ready),
    .config_enable_o (en),
    .ccff_head_o     (head),
    .ccff_tail_i     (tail),
    .busy_o          (busy),
    .done_o          (done),
    .bit_cnt_o       (bit_cnt),
    .rb_ones_o       (rb)
  );

  // Attached chain: head enters at bit 0, tail leaves from bit L-1.
  logic [L-1:0] chain = '0;
  assign tail = chain[L-1];
  always @(posedge clk) if (en) chain <= {chain[L-2:0], head};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] words [NW];
  logic [L-1:0] saved_chain;

  task automatic fill(input int mode);
    for (int k = 0; k < NW; k++) begin
      case (mode)
        1:       words[k] = '1;
        2:       words[k] = (k == 0) ? W'(1) : '0;
        default: words[k] = W'($urandom);
      endcase
    end
  endtask

  function automatic logic stream_bit(input int i);
    return words[i / W][i % W];
  endfunction

  // stall: 0 none, 1 withhold valid on the first three ready cycles after two words, 2 random.
  // stop_at >= 0: abort (or reset when use_rst) in the shift cycle where bit_cnt == stop_at.
  task automatic run_load(input int stall, input int stop_at, input bit use_rst);
    int           widx = 0;
    int           sidx = 0;
    int           gaps = 0;
    int           stall_left = 3;
    int           last_en = -1;
    int           done_cyc = -1;
    bit           finished = 0;
    logic [L-1:0] prev = chain;
    logic [L-1:0] exp_chain;
    int           exp_rb;

    @(negedge clk);
    start = 1'b1; abort = 1'b0; valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cnt", bit_cnt, 0);
    check("start_rb", rb, 0);

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        finished = 1;
        check("done_cnt", bit_cnt, L);
        check("done_busy", busy, 0);
        check("done_en", en, 0);
        check("done_ready", ready, 0);
      end else if (en) begin
        check("head", head, stream_bit(sidx));
        check("shift_cnt", bit_cnt, sidx);
        check("ready_shift", ready, (sidx % W == W - 1) && (sidx != L - 1));
        last_en = cyc;
        sidx++;
      end else begin
        check("load_head", head, 0);
        check("load_ready", ready, 1);
        check("load_busy", busy, 1);
        gaps++;
      end

      if (finished) begin
        start = 1'b0; valid = 1'b0;
      end else if (stop_at >= 0 && en && int'(bit_cnt) == stop_at) begin
        exp_rb = 0;
`ifdef CCFF_LOADER_READBACK_EN
        for (int i = 0; i < stop_at; i++) exp_rb += int'(prev[L-1-i]);
`endif
        if (use_rst) begin
          rst = 1'b1; start = 1'b0; valid = 1'b0;
          #1;
          check("rst_ready", ready, 0);
          check("rst_en", en, 0);
          check("rst_head", head, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_cnt", bit_cnt, 0);
          check("rst_rb", rb, 0);
          @(negedge clk);
          rst = 1'b0;
        end else begin
          start = 1'b0; abort = 1'b1; valid = 1'b1; data = words[widx];
          @(negedge clk);
          abort = 1'b0; valid = 1'b0;
          check("abort_en", en, 0);
          check("abort_ready", ready, 0);
          check("abort_busy", busy, 0);
          check("abort_cnt", bit_cnt, stop_at);
          check("abort_rb", rb, exp_rb);
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
            check("abort_idle_en", en, 0);
            check("abort_hold_cnt", bit_cnt, stop_at);
          end
        end
        return;
      end else begin
        start = 1'($urandom_range(0, 1));
        if (widx >= NW) valid = 1'b0;
        else if (stall == 1 && widx == 2 && stall_left > 0 && ready) begin
          valid = 1'b0;
          stall_left--;
        end else if (stall == 2) valid = ($urandom_range(0, 3) != 0);
        else valid = 1'b1;
        data = (widx < NW) ? words[widx] : W'($urandom);
        if (valid && ready) widx++;
        @(negedge clk);
      end
    end

    if (!finished) check("timeout", 0, 1);
    check("done_latency", done_cyc, last_en + 1);
    check("shift_total", sidx, L);
    check("words_used", widx, NW);
    if (stall == 0) check("gaps", gaps, 1);
    if (stall == 1) check("gaps_stall", gaps, 4);
    for (int i = 0; i < L; i++) exp_chain[L-1-i] = stream_bit(i);
    check("chain", chain, exp_chain);
`ifdef CCFF_LOADER_READBACK_EN
    exp_rb = $countones(prev);
`else
    exp_rb = 0;
`endif
    check("rb_final", rb, exp_rb);
    @(negedge clk);
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_cnt", bit_cnt, L);
    check("post_rb", rb, exp_rb);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
    #12;
    check("reset_ready", ready, 0);
    check("reset_en", en, 0);
    check("reset_head", head, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cnt", bit_cnt, 0);
    check("reset_rb", rb, 0);
    @(negedge clk);
    rst = 1'b0;

    fill(1); run_load(0, -1, 0);
    run_load(0, -1, 0);
    fill(0); run_load(0, -1, 0);
    saved_chain = chain;
    run_load(1, -1, 0);
    check("stall_chain", chain, saved_chain);
    fill(2); run_load(0, -1, 0);
    fill(0); run_load(2, -1, 0);
    fill(0); run_load(0, 30, 0);
    run_load(0, 31, 0);
    fill(0); run_load(0, -1, 0);
    fill(0); run_load(0, 20, 1);
    fill(0); run_load(2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
